vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Generates the 640x480@60 Hz VGA raster for the draw path: pixel-clock enable, draw coordinates DrX/DrY, HS/VS and blanking.
- Produces the coordinates that draw_map consumes. Drives the sync pins of monitor 1 directly. Its HS/VS also feed the GPIO header for monitor 2 via draw_map.
- Sync and blank outputs have a programmable pixel delay, so they line up with the latency of the drawing pipeline.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, HS pulse width (pixels)
- H_BP, 48, horizontal back porch; H_TOTAL = sum of the four = 800
- V_VISIBLE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, VS pulse width (lines)
- V_BP, 33, vertical back porch; V_TOTAL = 525
- CLK_DIV, 2, Clk cycles per pixel (>=2)
- SYNC_DELAY, 2, pixel delay of HS/VS/BLANK_N relative to DrX/DrY (0..7)

Ports:
- Clk  in  1  system clock (50 MHz)
- Reset  in  1  synchronous, active-high reset
- pixel_ce  out  1  one-Clk pulse per pixel
- DrX  out  10  current pixel column, 0..H_TOTAL-1
- DrY  out  10  current line, 0..V_TOTAL-1
- VGA_CLK  out  1  pixel clock to DAC
- VGA_HS  out  1  horizontal sync, active low, delayed
- VGA_VS  out  1  vertical sync, active low, delayed
- VGA_BLANK_N  out  1  high in visible area, delayed
- VGA_SYNC_N  out  1  tied 0
- line_start  out  1  one-Clk pulse when DrX becomes 0
- frame_start  out  1  one-Clk pulse when DrX=0 and DrY=0 begins
- frame_count  out  16  completed frames, wraps 65535->0

Behaviour:
- **Clock and reset.** One clock domain (Clk). Reset is synchronous and active-high, and overrides everything on the same edge.
- **Reset values.**
  - div=0, DrX=0, DrY=0, frame_count=0.
  - line_start=0, frame_start=0.
  - VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0.
  - All delay-pipeline stages load the inactive values (HS=1, VS=1, BLANK_N=0).
- **Divider.**
  - div counts 0..CLK_DIV-1 and wraps.
  - pixel_ce = (div==CLK_DIV-1), a combinational decode of the registered div.
  - VGA_CLK = (div >= CLK_DIV/2). For CLK_DIV=2 this equals div[0].
  - The first pixel_ce after reset release occurs in cycle CLK_DIV-1.
- **Counters.** They advance only on edges where pixel_ce=1.
  - DrX increments; at H_TOTAL-1 it wraps to 0.
  - DrY increments only on the DrX wrap edge; at V_TOTAL-1 (together with the DrX wrap) it wraps to 0.
  - Each DrX value is held for exactly CLK_DIV Clk cycles.
- **Raw decode** (combinational on DrX/DrY):
  - hs_raw = 0 iff H_VISIBLE+H_FP <= DrX < H_VISIBLE+H_FP+H_SYNC, i.e. 656..751.
  - vs_raw = 0 iff V_VISIBLE+V_FP <= DrY < V_VISIBLE+V_FP+V_SYNC, i.e. 490..491.
  - blank_raw_n = (DrX<H_VISIBLE) & (DrY<V_VISIBLE).
- **Delay line.**
  - A SYNC_DELAY-stage shift register carries {hs, vs, blank_n} and shifts on pixel_ce only.
  - Outputs come from the last stage.
  - SYNC_DELAY=0 means the outputs equal the raw decode combinationally.
  - Net effect: the VGA_HS falling edge appears while DrX = 656+SYNC_DELAY (mod H_TOTAL, DrY carried accordingly).
- **Pulses.**
  - line_start is registered, high for exactly the one Clk cycle after the edge on which DrX loads 0.
  - frame_start is the same, for the edge on which DrX and DrY both load 0.
  - frame_start implies line_start.
  - Reset does not generate either pulse.
- **frame_count.** Increments on the frame-wrap edge and wraps modulo 2^16.
- **Reset mid-frame.** All state returns to the reset values on the next edge. No partial HS pulse survives: the pipeline is cleared to inactive.
- **Arithmetic.** Compares are done at 10 bits unsigned; all parameter sums must be <1024 (elaboration check).

Decomposition:
- Package vga_timing_pkg holds:
  - the default timing constants (H_*/V_*, H_TOTAL, V_TOTAL);
  - a packed struct sync_t {hs, vs, blank_n}, also imported by draw_map.
- One sub-module, sync_delay_line: a parameterized-depth shift register of sync_t with clock enable and synchronous reset value.

Test Plan:
- **Reset release.** Hold Reset 5 cycles, then release → DrX=0, DrY=0, HS=VS=1, BLANK_N=0 during reset; pixel_ce first high in cycle 1, then every 2nd cycle.
- **Horizontal sync, SYNC_DELAY=0.** Run one line → VGA_HS low for exactly 96 pixels (192 Clk) starting DrX=656; BLANK_N high for DrX 0..639 on DrY=0.
- **Line and frame wrap.**
  - DrX 799→0 → DrY increments and line_start pulses for 1 Clk.
  - At DrX=799, DrY=524 → both wrap to 0, frame_start and line_start pulse, frame_count 0→1.
  - One full frame = 800*525*2 = 840000 Clk.
- **Delayed sync, SYNC_DELAY=2.** HS falls while DrX=658; VS low across DrY 490..491 shifted by 2 pixels; BLANK_N falls at DrX=642.
- **Reset mid-operation.** Assert Reset at DrX=700 (inside the HS pulse) → VGA_HS=1 on the next edge, counters 0, no frame_start pulse, frame_count 0.
- **frame_count wrap.** Force frame_count to 65535 and complete a frame → 0.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - default 640x480@60 timing constants and sync bundle type
package vga_timing_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    // Sync/blank bundle carried through the delay line; also consumed by draw_map.
    typedef struct packed {
        logic hs;
        logic vs;
        logic blank_n;
    } sync_t;

    // Inactive levels: syncs deasserted (high), blanking active (low).
    localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0};

endpackage

// File: rtl/vga_timing_if.sv
// rtl/vga_timing_if.sv - raster timing outputs bundle
interface vga_timing_if;

    logic        pixel_ce;
    logic [9:0]  DrX;
    logic [9:0]  DrY;
    logic        VGA_CLK;
    logic        VGA_HS;
    logic        VGA_VS;
    logic        VGA_BLANK_N;
    logic        VGA_SYNC_N;
    logic        line_start;
    logic        frame_start;
    logic [15:0] frame_count;

    modport master (
        output pixel_ce, DrX, DrY, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N,
               VGA_SYNC_N, line_start, frame_start, frame_count
    );

    modport slave (
        input  pixel_ce, DrX, DrY, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N,
               VGA_SYNC_N, line_start, frame_start, frame_count
    );

endinterface

// File: rtl/sync_delay_line.sv
// rtl/sync_delay_line.sv - clock-enabled shift register of sync_t with idle reset value
module sync_delay_line
    import vga_timing_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  ce,
    input  sync_t din,
    output sync_t dout
);

    // A zero-depth line still keeps one (unused) stage so the port list stays uniform.
    localparam int N = (DEPTH == 0) ? 1 : DEPTH;

    sync_t stages [N];

    // Shift one stage per pixel; reset flushes every stage to the inactive levels.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                stages[i] <= SYNC_IDLE;
            end
        end else if (ce) begin
            stages[0] <= din;
            for (int i = 1; i < N; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign dout = (DEPTH == 0) ? din : stages[N-1];

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster generator: pixel enable, coordinates, delayed sync/blank
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE  = vga_timing_pkg::H_VISIBLE,
    parameter int H_FP       = vga_timing_pkg::H_FP,
    parameter int H_SYNC     = vga_timing_pkg::H_SYNC,
    parameter int H_BP       = vga_timing_pkg::H_BP,
    parameter int V_VISIBLE  = vga_timing_pkg::V_VISIBLE,
    parameter int V_FP       = vga_timing_pkg::V_FP,
    parameter int V_SYNC     = vga_timing_pkg::V_SYNC,
    parameter int V_BP       = vga_timing_pkg::V_BP,
    parameter int CLK_DIV    = 2,
    parameter int SYNC_DELAY = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    vga_timing_if.master vga
);

    localparam int HT = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_VISIBLE + V_FP + V_SYNC + V_BP;

    // All coordinate compares are 10-bit unsigned, so every boundary must fit.
    if (HT >= 1024 || VT >= 1024) begin : g_bad_totals
        $error("vga_timing_gen: H/V totals must be below 1024");
    end
    if (CLK_DIV < 2) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be at least 2");
    end
    if (SYNC_DELAY < 0 || SYNC_DELAY > 7) begin : g_bad_delay
        $error("vga_timing_gen: SYNC_DELAY must be 0..7");
    end

    localparam int DIV_W = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    localparam logic [9:0] X_LAST   = 10'(HT - 1);
    localparam logic [9:0] Y_LAST   = 10'(VT - 1);
    localparam logic [9:0] X_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] Y_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div;
    logic             pixel_ce;
    logic [9:0]       dr_x;
    logic [9:0]       dr_y;
    logic             x_wrap;
    logic             y_wrap;
    logic             line_start_q;
    logic             frame_start_q;
    logic [15:0]      frame_cnt_q;
    sync_t            sync_raw;
    sync_t            sync_dly;

    assign pixel_ce = (div == DIV_LAST);
    assign x_wrap   = (dr_x == X_LAST);
    assign y_wrap   = (dr_y == Y_LAST);

    // Pixel divider: counts 0..CLK_DIV-1, pixel_ce decodes the last count.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            div <= '0;
        end else if (pixel_ce) begin
            div <= '0;
        end else begin
            div <= div + DIV_ONE;
        end
    end

    // Raster counters and one-cycle line/frame start pulses.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            dr_x          <= '0;
            dr_y          <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            line_start_q  <= pixel_ce & x_wrap;
            frame_start_q <= pixel_ce & x_wrap & y_wrap;
            if (pixel_ce) begin
                if (x_wrap) begin
                    dr_x <= '0;
                    dr_y <= y_wrap ? 10'd0 : dr_y + 10'd1;
                end else begin
                    dr_x <= dr_x + 10'd1;
                end
            end
        end
    end

    // Completed-frame counter, bumped on the frame-wrap edge; wraps naturally at 16 bits.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_cnt_q <= '0;
        end else if (pixel_ce && x_wrap && y_wrap) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    // Undelayed sync/blank decode of the current coordinates.
    always_comb begin
        sync_raw         = SYNC_IDLE;
        sync_raw.hs      = !((dr_x >= HS_START) && (dr_x < HS_END));
        sync_raw.vs      = !((dr_y >= VS_START) && (dr_y < VS_END));
        sync_raw.blank_n = (dr_x < X_VIS) && (dr_y < Y_VIS);
    end

    sync_delay_line #(
        .DEPTH (SYNC_DELAY)
    ) u_delay (
        .clk  (Clk),
        .rst  (Reset),
        .ce   (pixel_ce),
        .din  (sync_raw),
        .dout (sync_dly)
    );

    assign vga.pixel_ce    = pixel_ce;
    assign vga.DrX         = dr_x;
    assign vga.DrY         = dr_y;
    assign vga.VGA_CLK     = (div >= DIV_HALF);
    assign vga.VGA_HS      = sync_dly.hs;
    assign vga.VGA_VS      = sync_dly.vs;
    assign vga.VGA_BLANK_N = sync_dly.blank_n;
    assign vga.VGA_SYNC_N  = 1'b0;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;
    assign vga.frame_count = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen with a cycle-count reference model
module tb_vga_timing_gen;

    localparam int HV = 16, HF = 4, HS = 6, HB = 6;
    localparam int VV = 8,  VF = 2, VS = 2, VB = 3;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int CD = 2;
    localparam int FRAME_PIX = HT * VT;

    typedef struct {
        logic        pixel_ce;
        logic        vga_clk;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        hs;
        logic        vs;
        logic        bn;
        logic        ls;
        logic        fs;
        logic [15:0] fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int vectors = 0;
    int errors  = 0;
    int t       = 0;
    int base0   = 0;
    int base2   = 0;

    vga_timing_if if0 ();
    vga_timing_if if2 ();

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CLK_DIV(CD), .SYNC_DELAY(0)
    ) dut0 (
        .Clk(clk), .Reset(rst), .vga(if0)
    );

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CLK_DIV(CD), .SYNC_DELAY(2)
    ) dut2 (
        .Clk(clk), .Reset(rst), .vga(if2)
    );

    always #5 clk = ~clk;

    // Expected outputs from the number of clocks since reset release.
    function automatic exp_t model(input int tc, input int d, input int base);
        exp_t e;
        int div, p, q, qx, qy;
        div = tc % CD;
        p   = tc / CD;
        e.pixel_ce = (div == CD - 1);
        e.vga_clk  = (div >= CD / 2);
        e.x  = 10'(p % HT);
        e.y  = 10'((p / HT) % VT);
        q = p - d;
        if (q < 0) begin
            e.hs = 1'b1; e.vs = 1'b1; e.bn = 1'b0;
        end else begin
            qx = q % HT;
            qy = (q / HT) % VT;
            e.hs = !(qx >= HV + HF && qx < HV + HF + HS);
            e.vs = !(qy >= VV + VF && qy < VV + VF + VS);
            e.bn = (qx < HV) && (qy < VV);
        end
        e.ls = (div == 0) && (p > 0) && (p % HT == 0);
        e.fs = (div == 0) && (p > 0) && (p % FRAME_PIX == 0);
        e.fc = 16'((base + p / FRAME_PIX) & 32'hFFFF);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, expv);
        end
    endtask

    task automatic check_all();
        exp_t e0, e2;
        e0 = model(t, 0, base0);
        e2 = model(t, 2, base2);
        chk("d0_pixel_ce", 16'(if0.pixel_ce),    16'(e0.pixel_ce));
        chk("d0_vga_clk",  16'(if0.VGA_CLK),     16'(e0.vga_clk));
        chk("d0_x",        16'(if0.DrX),         16'(e0.x));
        chk("d0_y",        16'(if0.DrY),         16'(e0.y));
        chk("d0_hs",       16'(if0.VGA_HS),      16'(e0.hs));
        chk("d0_vs",       16'(if0.VGA_VS),      16'(e0.vs));
        chk("d0_blank_n",  16'(if0.VGA_BLANK_N), 16'(e0.bn));
        chk("d0_sync_n",   16'(if0.VGA_SYNC_N),  16'h0);
        chk("d0_line_st",  16'(if0.line_start),  16'(e0.ls));
        chk("d0_frame_st", 16'(if0.frame_start), 16'(e0.fs));
        chk("d0_fcount",   if0.frame_count,      e0.fc);
        chk("d2_pixel_ce", 16'(if2.pixel_ce),    16'(e2.pixel_ce));
        chk("d2_vga_clk",  16'(if2.VGA_CLK),     16'(e2.vga_clk));
        chk("d2_x",        16'(if2.DrX),         16'(e2.x));
        chk("d2_y",        16'(if2.DrY),         16'(e2.y));
        chk("d2_hs",       16'(if2.VGA_HS),      16'(e2.hs));
        chk("d2_vs",       16'(if2.VGA_VS),      16'(e2.vs));
        chk("d2_blank_n",  16'(if2.VGA_BLANK_N), 16'(e2.bn));
        chk("d2_sync_n",   16'(if2.VGA_SYNC_N),  16'h0);
        chk("d2_line_st",  16'(if2.line_start),  16'(e2.ls));
        chk("d2_frame_st", 16'(if2.frame_start), 16'(e2.fs));
        chk("d2_fcount",   if2.frame_count,      e2.fc);
    endtask

    // One clock: advance the model on the edge, then check on the falling edge.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            t = 0; base0 = 0; base2 = 0;
        end else begin
            t++;
        end
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int budget;
        int hs0_low, hs2_low, first_low_x;
        logic found;

        // Reset held for 5 cycles, then released.
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) step();
        rst = 1'b0;

        // Two undisturbed frames.
        for (int i = 0; i < 2 * FRAME_PIX * CD; i++) step();

        // HS low time over exactly one line, and the delayed falling-edge column.
        found = 1'b0;
        for (budget = 0; budget < FRAME_PIX * CD && !found; budget++) begin
            step();
            found = if0.line_start;
        end
        chk("wait_line_start", 16'(found), 16'h1);
        hs0_low = 0; hs2_low = 0; first_low_x = -1;
        for (int i = 0; i < HT * CD; i++) begin
            if (!if0.VGA_HS) hs0_low++;
            if (!if2.VGA_HS) begin
                if (hs2_low == 0) first_low_x = int'(if2.DrX);
                hs2_low++;
            end
            step();
        end
        chk("hs0_low_clocks", 16'(hs0_low), 16'(HS * CD));
        chk("hs2_low_clocks", 16'(hs2_low), 16'(HS * CD));
        chk("hs2_fall_x",     16'(first_low_x), 16'(HV + HF + 2));

        // Reset in the middle of the HS pulse.
        found = 1'b0;
        for (budget = 0; budget < FRAME_PIX * CD && !found; budget++) begin
            step();
            found = (if0.DrX == 10'(HV + HF + 2));
        end
        chk("wait_mid_hs", 16'(found), 16'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_hs0",  16'(if0.VGA_HS),      16'h1);
        chk("mid_rst_hs2",  16'(if2.VGA_HS),      16'h1);
        chk("mid_rst_fs2",  16'(if2.frame_start), 16'h0);
        chk("mid_rst_fc2",  if2.frame_count,      16'h0);
        for (int i = 0; i < 300; i++) step();

        // Preload frame_count to 65535 and let the frame complete.
        found = 1'b0;
        for (budget = 0; budget < 2 * FRAME_PIX * CD && !found; budget++) begin
            step();
            found = (if2.DrY == 10'(VT - 1)) && (if2.DrX == 10'd0);
        end
        chk("wait_last_line", 16'(found), 16'h1);
        force dut2.frame_cnt_q = 16'hFFFF;
        base2 = 65535 - (t / CD) / FRAME_PIX;
        #1;
        release dut2.frame_cnt_q;
        for (int i = 0; i < HT * CD + 4; i++) step();
        chk("fcount_wrap", if2.frame_count, 16'h0);

        // Random run lengths interleaved with random reset pulses.
        for (int k = 0; k < 8; k++) begin
            int run, hold;
            run  = int'($urandom_range(50, 1500));
            hold = int'($urandom_range(1, 3));
            for (int i = 0; i < run; i++) step();
            rst = 1'b1;
            for (int i = 0; i < hold; i++) step();
            rst = 1'b0;
        end
        for (int i = 0; i < FRAME_PIX * CD + 10; i++) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
